// File: rtl/dec_ex_core.sv
// Decode/execute stage of the MIPS-subset pipeline: regfile with write-through reads,
// combinational ALU/branch/multiply, all results registered at the stage boundary.
module dec_ex_core (
    input  logic        Clock,
    input  logic        nReset,
    input  logic [31:0] Instruction,
    input  logic [31:0] PCin,
    input  logic        RegWriteIn,
    input  logic [4:0]  RAddrIn,
    input  logic [31:0] RData,
    input  logic [4:0]  RegAddr,
    output logic [31:0] RegData,
    output logic [31:0] Result,
    output logic [31:0] StoreData,
    output logic [4:0]  RAddrOut,
    output logic        RegWriteOut,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        BranchTaken,
    output logic [31:0] BranchAddr,
    output logic        C,
    output logic        Z,
    output logic        O,
    output logic        N,
    output logic        Illegal
);
    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  raddr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        br_taken;
        logic [31:0] br_addr;
        logic        c, z, o, n;
        logic        illegal;
    } ex_out_t;

    ex_out_t     out_d, out_q;
    logic [31:0] rf_q [32];
    logic [31:0] hi_q, lo_q, hi_d, lo_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, sext, zext, opb, pc4, diff, br_tgt, jmp_tgt;
    logic [32:0] sum33;
    logic [63:0] prod_s, prod_u;
    logic        add_ovf, sub_ovf;

    assign op    = Instruction[31:26];
    assign rs    = Instruction[25:21];
    assign rt    = Instruction[20:16];
    assign rd    = Instruction[15:11];
    assign shamt = Instruction[10:6];
    assign funct = Instruction[5:0];
    assign imm   = Instruction[15:0];

    // Reads see a same-cycle write-back so the caller needs no bypass of its own.
    assign rs_val  = (rs == 5'd0) ? '0 : (RegWriteIn && RAddrIn == rs) ? RData : rf_q[rs];
    assign rt_val  = (rt == 5'd0) ? '0 : (RegWriteIn && RAddrIn == rt) ? RData : rf_q[rt];
    assign RegData = (RegAddr == 5'd0) ? '0 :
                     (RegWriteIn && RAddrIn == RegAddr) ? RData : rf_q[RegAddr];

    assign sext    = {{16{imm[15]}}, imm};
    assign zext    = {16'h0, imm};
    assign opb     = (op == 6'h00) ? rt_val : sext;
    assign sum33   = {1'b0, rs_val} + {1'b0, opb};
    assign diff    = rs_val - rt_val;
    assign add_ovf = (rs_val[31] == opb[31]) && (sum33[31] != rs_val[31]);
    assign sub_ovf = (rs_val[31] != rt_val[31]) && (diff[31] != rs_val[31]);
    assign prod_s  = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u  = {32'h0, rs_val} * {32'h0, rt_val};
    assign pc4     = PCin + 32'd4;
    assign br_tgt  = pc4 + {sext[29:0], 2'b00};
    assign jmp_tgt = {pc4[31:28], Instruction[25:0], 2'b00};

    always_comb begin
        logic [31:0] res;
        logic [4:0]  dest;
        logic        wr, arith, ovf, cy;
        out_d = '0;
        hi_d  = hi_q;
        lo_d  = lo_q;
        res   = '0;
        dest  = rt;
        wr    = 1'b0;
        arith = 1'b0;
        ovf   = 1'b0;
        cy    = 1'b0;
        unique case (op)
            6'h00: begin
                dest = rd;
                wr   = 1'b1;
                unique case (funct)
                    6'h20: begin res = sum33[31:0]; cy = sum33[32]; ovf = add_ovf; arith = 1'b1; end
                    6'h21: begin res = sum33[31:0]; cy = sum33[32]; arith = 1'b1; end
                    6'h22: begin res = diff; cy = (rs_val >= rt_val); ovf = sub_ovf; arith = 1'b1; end
                    6'h23: begin res = diff; cy = (rs_val >= rt_val); arith = 1'b1; end
                    6'h24: res = rs_val & rt_val;
                    6'h25: res = rs_val | rt_val;
                    6'h26: res = rs_val ^ rt_val;
                    6'h27: res = ~(rs_val | rt_val);
                    6'h2A: res = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: res = {31'h0, rs_val < rt_val};
                    6'h00: res = rt_val << shamt;
                    6'h02: res = rt_val >> shamt;
                    6'h03: res = $unsigned($signed(rt_val) >>> shamt);
                    6'h08: begin wr = 1'b0; out_d.br_taken = 1'b1; out_d.br_addr = rs_val; end
                    6'h10: res = hi_q;
                    6'h12: res = lo_q;
                    6'h18: begin wr = 1'b0; {hi_d, lo_d} = prod_s; end
                    6'h19: begin wr = 1'b0; {hi_d, lo_d} = prod_u; end
                    default: begin wr = 1'b0; out_d.illegal = 1'b1; end
                endcase
            end
            6'h08: begin res = sum33[31:0]; cy = sum33[32]; ovf = add_ovf; arith = 1'b1; wr = 1'b1; end
            6'h09: begin res = sum33[31:0]; cy = sum33[32]; arith = 1'b1; wr = 1'b1; end
            6'h0A: begin res = {31'h0, $signed(rs_val) < $signed(sext)}; wr = 1'b1; end
            6'h0B: begin res = {31'h0, rs_val < sext}; wr = 1'b1; end
            6'h0C: begin res = rs_val & zext; wr = 1'b1; end
            6'h0D: begin res = rs_val | zext; wr = 1'b1; end
            6'h0E: begin res = rs_val ^ zext; wr = 1'b1; end
            6'h0F: begin res = {imm, 16'h0}; wr = 1'b1; end
            6'h23: begin res = sum33[31:0]; wr = 1'b1; out_d.mem_read = 1'b1; end
            6'h2B: begin res = sum33[31:0]; out_d.mem_write = 1'b1; out_d.store_data = rt_val; end
            6'h04: begin out_d.br_addr = br_tgt; out_d.br_taken = (rs_val == rt_val); end
            6'h05: begin out_d.br_addr = br_tgt; out_d.br_taken = (rs_val != rt_val); end
            6'h1C: begin
                unique case (funct)
                    6'h00:   {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                    6'h01:   {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
                    default: out_d.illegal = 1'b1;
                endcase
            end
            6'h02: begin out_d.br_taken = 1'b1; out_d.br_addr = jmp_tgt; end
            6'h03: begin
                out_d.br_taken = 1'b1;
                out_d.br_addr  = jmp_tgt;
                res            = pc4;
                dest           = 5'd31;
                wr             = 1'b1;
            end
            default: out_d.illegal = 1'b1;
        endcase

        // A write aimed at r0 (including the all-zero NOP) is reported as no write.
        out_d.result    = res;
        out_d.reg_write = wr && (dest != 5'd0);
        out_d.raddr     = out_d.reg_write ? dest : 5'd0;
        if (arith) begin
            out_d.c = cy;
            out_d.o = ovf;
            out_d.z = (res == 32'h0);
            out_d.n = res[31];
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (RegWriteIn && RAddrIn != 5'd0) begin
            rf_q[RAddrIn] <= RData;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            out_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            out_q <= out_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign Result      = out_q.result;
    assign StoreData   = out_q.store_data;
    assign RAddrOut    = out_q.raddr;
    assign RegWriteOut = out_q.reg_write;
    assign MemRead     = out_q.mem_read;
    assign MemWrite    = out_q.mem_write;
    assign BranchTaken = out_q.br_taken;
    assign BranchAddr  = out_q.br_addr;
    assign C           = out_q.c;
    assign Z           = out_q.z;
    assign O           = out_q.o;
    assign N           = out_q.n;
    assign Illegal     = out_q.illegal;
endmodule

// File: tb/tb_dec_ex_core.sv
// Scoreboarded bench for dec_ex_core: directed cases plus random instructions against a
// behavioural model; a monitor pops expected packets one cycle after each issue.
module tb_dec_ex_core;
    logic        Clock = 1'b0;
    logic        nReset;
    logic [31:0] Instruction, PCin, RData;
    logic        RegWriteIn;
    logic [4:0]  RAddrIn, RegAddr;
    logic [31:0] RegData, Result, StoreData, BranchAddr;
    logic [4:0]  RAddrOut;
    logic        RegWriteOut, MemRead, MemWrite, BranchTaken, C, Z, O, N, Illegal;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  ra;
        logic        we, mr, mw, bt;
        logic [31:0] ba;
        logic        c, z, o, n, ill;
    } exp_t;

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    exp_t        qexp[$];
    exp_t        act;
    int          errors = 0;
    int          checks = 0;
    int          nout   = 0;
    logic [31:0] m_rf [32];
    logic [63:0] m_acc;

    dec_ex_core dut (
        .Clock(Clock), .nReset(nReset), .Instruction(Instruction), .PCin(PCin),
        .RegWriteIn(RegWriteIn), .RAddrIn(RAddrIn), .RData(RData), .RegAddr(RegAddr),
        .RegData(RegData), .Result(Result), .StoreData(StoreData), .RAddrOut(RAddrOut),
        .RegWriteOut(RegWriteOut), .MemRead(MemRead), .MemWrite(MemWrite),
        .BranchTaken(BranchTaken), .BranchAddr(BranchAddr),
        .C(C), .Z(Z), .O(O), .N(N), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    assign act = {Result, StoreData, RAddrOut, RegWriteOut, MemRead, MemWrite, BranchTaken,
                  BranchAddr, C, Z, O, N, Illegal};

    function automatic logic [31:0] rv(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (RegWriteIn && RAddrIn == a) return RData;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] R(input logic [5:0] f, input logic [4:0] s, t, d, sh);
        return {6'h00, s, t, d, sh, f};
    endfunction

    function automatic logic [31:0] I(input logic [5:0] o, input logic [4:0] s, t,
                                      input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    // Reference: architectural meaning of the current inputs, then commit write-back and HI/LO.
    task automatic model(output exp_t e);
        logic [5:0]  op, fn;
        logic [4:0]  rd, rt, sh;
        logic [15:0] im;
        logic [31:0] a, b, simm, pc4, r;
        logic [63:0] u;
        longint      s;
        logic        wr, ar, ov, cy;
        logic [4:0]  dest;
        op = Instruction[31:26]; fn = Instruction[5:0]; rd = Instruction[15:11];
        rt = Instruction[20:16]; sh = Instruction[10:6]; im = Instruction[15:0];
        a = rv(Instruction[25:21]); b = rv(rt);
        simm = {{16{im[15]}}, im}; pc4 = PCin + 32'd4;
        e = '0; r = 0; wr = 0; ar = 0; ov = 0; cy = 0; dest = rt;
        if (op == 6'h00) begin
            dest = rd; wr = 1;
            case (fn)
                6'h20, 6'h21: begin
                    r = a + b; u = {32'h0, a} + {32'h0, b}; cy = (u > 64'hFFFF_FFFF); ar = 1;
                    s = longint'($signed(a)) + longint'($signed(b));
                    ov = (fn == 6'h20) && (s > MAXI || s < MINI);
                end
                6'h22, 6'h23: begin
                    r = a - b; cy = (a >= b); ar = 1;
                    s = longint'($signed(a)) - longint'($signed(b));
                    ov = (fn == 6'h22) && (s > MAXI || s < MINI);
                end
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = ($signed(a) < $signed(b)) ? 1 : 0;
                6'h2B: r = (a < b) ? 1 : 0;
                6'h00: r = b << sh;
                6'h02: r = b >> sh;
                6'h03: r = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
                6'h08: begin wr = 0; e.bt = 1; e.ba = a; end
                6'h10: r = m_acc[63:32];
                6'h12: r = m_acc[31:0];
                6'h18: begin wr = 0; m_acc = longint'($signed(a)) * longint'($signed(b)); end
                6'h19: begin wr = 0; m_acc = {32'h0, a} * {32'h0, b}; end
                default: begin wr = 0; e.ill = 1; end
            endcase
        end else begin
            case (op)
                6'h08, 6'h09: begin
                    r = a + simm; u = {32'h0, a} + {32'h0, simm}; cy = (u > 64'hFFFF_FFFF);
                    ar = 1; wr = 1;
                    s = longint'($signed(a)) + longint'($signed(simm));
                    ov = (op == 6'h08) && (s > MAXI || s < MINI);
                end
                6'h0A: begin r = ($signed(a) < $signed(simm)) ? 1 : 0; wr = 1; end
                6'h0B: begin r = (a < simm) ? 1 : 0; wr = 1; end
                6'h0C: begin r = a & {16'h0, im}; wr = 1; end
                6'h0D: begin r = a | {16'h0, im}; wr = 1; end
                6'h0E: begin r = a ^ {16'h0, im}; wr = 1; end
                6'h0F: begin r = {im, 16'h0}; wr = 1; end
                6'h23: begin r = a + simm; wr = 1; e.mr = 1; end
                6'h2B: begin r = a + simm; e.mw = 1; e.sd = b; end
                6'h04: begin e.ba = pc4 + simm * 4; e.bt = (a == b); end
                6'h05: begin e.ba = pc4 + simm * 4; e.bt = (a != b); end
                6'h1C: begin
                    if (fn == 6'h00) m_acc = m_acc + 64'(longint'($signed(a)) * longint'($signed(b)));
                    else if (fn == 6'h01) m_acc = m_acc + {32'h0, a} * {32'h0, b};
                    else e.ill = 1;
                end
                6'h02: begin e.bt = 1; e.ba = {pc4[31:28], Instruction[25:0], 2'b00}; end
                6'h03: begin
                    e.bt = 1; e.ba = {pc4[31:28], Instruction[25:0], 2'b00};
                    r = pc4; dest = 5'd31; wr = 1;
                end
                default: e.ill = 1;
            endcase
        end
        e.res = r;
        e.we  = wr && dest != 0;
        e.ra  = e.we ? dest : 5'd0;
        if (ar) begin e.c = cy; e.o = ov; e.z = (r == 0); e.n = r[31]; end
        if (RegWriteIn && RAddrIn != 0) m_rf[RAddrIn] = RData;
    endtask

    task automatic issue(input logic [31:0] ins, pc, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra);
        exp_t e;
        @(negedge Clock);
        Instruction = ins; PCin = pc; RegWriteIn = we; RAddrIn = wa; RData = wd; RegAddr = ra;
        #1;
        checks++;
        if (RegData !== rv(ra)) begin
            errors++;
            $display("FAIL regdata r%0d got=%h want=%h", ra, RegData, rv(ra));
        end
        model(e);
        qexp.push_back(e);
    endtask

    task automatic do_reset(input logic [31:0] inflight);
        @(negedge Clock);
        Instruction = inflight; PCin = 32'h80; RegWriteIn = 0; RAddrIn = 0; RData = 0;
        #2 nReset = 0;
        #1;
        checks++;
        if (act !== '0) begin errors++; $display("FAIL reset_outs got=%h want=0", act); end
        for (int i = 0; i < 32; i++) begin
            RegAddr = 5'(i);
            #1;
            checks++;
            if (RegData !== 32'h0) begin
                errors++; $display("FAIL reset_regdata r%0d got=%h want=0", i, RegData);
            end
        end
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        m_acc = 0;
        repeat (2) @(negedge Clock);
        Instruction = 0;
        nReset = 1;
        #1;
        checks++;
        if (act !== '0) begin errors++; $display("FAIL post_release got=%h want=0", act); end
    endtask

    always begin
        exp_t e;
        @(posedge Clock);
        #1;
        if (qexp.size() > 0) begin
            e = qexp.pop_front();
            checks++;
            nout++;
            if (act !== e) begin
                errors++;
                $display("FAIL out#%0d got res=%h sd=%h ra=%0d we=%b mr=%b mw=%b bt=%b ba=%h czon=%b%b%b%b ill=%b want res=%h sd=%h ra=%0d we=%b mr=%b mw=%b bt=%b ba=%h czon=%b%b%b%b ill=%b",
                         nout, act.res, act.sd, act.ra, act.we, act.mr, act.mw, act.bt, act.ba,
                         act.c, act.z, act.o, act.n, act.ill, e.res, e.sd, e.ra, e.we, e.mr,
                         e.mw, e.bt, e.ba, e.c, e.z, e.o, e.n, e.ill);
            end
        end
    end

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 8));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [5:0]  rf [18];
        logic [5:0]  io [12];
        logic [4:0]  s, t, d;
        logic [15:0] im;
        rf = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
               6'h00, 6'h02, 6'h03, 6'h08, 6'h10, 6'h12, 6'h18, 6'h19};
        io = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
        s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7));
        d = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0: im = 16'h7FFF;
            1: im = 16'h8000;
            2: im = 16'hFFFF;
            default: im = 16'($urandom);
        endcase
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return R(rf[$urandom_range(0, 17)], s, t, d, 5'($urandom));
            4, 5, 6:    return I(io[$urandom_range(0, 11)], s, t, im);
            7:          return {6'h1C, s, t, d, 5'h0, 6'($urandom_range(0, 2))};
            8:          return {($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03, 26'($urandom)};
            default: begin
                case ($urandom_range(0, 2))
                    0: return {6'h3F, 26'($urandom)};
                    1: return R(6'h01, s, t, d, 5'h0);
                    default: return {6'h1C, s, t, d, 5'h0, 6'h05};
                endcase
            end
        endcase
    endfunction

    initial begin
        nReset = 0; Instruction = 0; PCin = 0; RegWriteIn = 0; RAddrIn = 0; RData = 0;
        RegAddr = 0;
        do_reset(32'h0);
        issue(R(6'h10, 0, 0, 9, 0), 32'h0, 0, 0, 0, 0);
        issue(R(6'h20, 5, 5, 3, 0), 32'h4, 1, 5, 32'd7, 5);
        issue(I(6'h08, 0, 1, 16'h7FFF), 32'h8, 1, 0, 32'hDEAD_BEEF, 0);
        issue(32'h0, 32'hC, 1, 2, 32'h7FFF_FFFF, 0);
        issue(32'h0, 32'h10, 1, 4, 32'h1, 2);
        issue(R(6'h20, 2, 4, 6, 0), 32'h14, 0, 0, 0, 4);
        issue(32'h0, 32'h18, 1, 1, 32'h5, 1);
        issue(I(6'h04, 1, 1, 16'hFFFF), 32'h100, 0, 0, 0, 1);
        issue(I(6'h05, 1, 1, 16'hFFFF), 32'h100, 0, 0, 0, 1);
        issue(32'h0, 32'h20, 1, 7, 32'hFFFF_FFFE, 7);
        issue(32'h0, 32'h24, 1, 8, 32'd3, 8);
        issue(R(6'h18, 7, 8, 0, 0), 32'h28, 0, 0, 0, 0);
        issue(R(6'h10, 0, 0, 9, 0), 32'h2C, 0, 0, 0, 0);
        issue(R(6'h12, 0, 0, 10, 0), 32'h30, 1, 11, 32'd1, 11);
        issue({6'h1C, 5'd11, 5'd11, 5'd0, 5'd0, 6'h01}, 32'h34, 0, 0, 0, 0);
        issue(R(6'h12, 0, 0, 10, 0), 32'h38, 0, 0, 0, 0);
        issue(R(6'h10, 0, 0, 9, 0), 32'h3C, 0, 0, 0, 0);
        issue({6'h03, 26'h40}, 32'h200, 0, 0, 0, 0);
        issue({6'h3F, 26'h0}, 32'h204, 0, 0, 0, 0);
        issue(I(6'h2B, 2, 7, 16'hFFFC), 32'h208, 0, 0, 0, 0);
        issue(I(6'h23, 8, 9, 16'h0010), 32'h20C, 0, 0, 0, 0);
        @(negedge Clock);
        Instruction = 0; RegWriteIn = 0;
        do_reset(R(6'h18, 7, 8, 0, 0));
        issue(R(6'h10, 0, 0, 9, 0), 32'h0, 0, 0, 0, 0);
        for (int k = 0; k < 500; k++) begin
            issue(rnd_instr(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 8)), rnd_data(),
                  5'($urandom_range(0, 31)));
        end
        @(negedge Clock);
        Instruction = 0; RegWriteIn = 0;
        @(posedge Clock);
        #2;
        checks++;
        if (qexp.size() != 0) begin
            errors++; $display("FAIL drain pending=%0d want=0", qexp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
